// File: rtl/fir_cmplx_seq_pkg.sv
// Shared types and defaults for the time-multiplexed complex FIR sequencer.
// Also used by the channel filter top so both agree on default tap/decimation.
package fir_cmplx_seq_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_MAC,
        S_WRITE
    } seq_state_t;

    localparam int DEF_TAPS       = 20;
    localparam int DEF_DECIMATION = 1;

    // A modulo-1 counter still needs a one-bit register to stay legal.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/fir_cmplx_seq_if.sv
// Datapath-facing bundle: input FIFO flags/pop, MAC control and output FIFO write.
// The sequencer is the master; FIFOs and the MAC sit on the slave side.
interface fir_cmplx_seq_if #(
    parameter int TAP_W = 5
);
    logic             i_empty;
    logic             q_empty;
    logic             in_rd_en;
    logic             shift_en;
    logic             mac_en;
    logic             mac_clr;
    logic             mac_last;
    logic [TAP_W-1:0] tap_idx;
    logic             y_full;
    logic             y_wr_en;

    modport master (
        input  i_empty, q_empty, y_full,
        output in_rd_en, shift_en, mac_en, mac_clr, mac_last, tap_idx, y_wr_en
    );

    modport slave (
        output i_empty, q_empty, y_full,
        input  in_rd_en, shift_en, mac_en, mac_clr, mac_last, tap_idx, y_wr_en
    );
endinterface

// File: rtl/fir_cmplx_seq_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the increment that returns to 0.
// wrap is combinational so the caller can change state in the same cycle.
module mod_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q, count_d;

    assign wrap  = inc & (count_q == LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fir_cmplx_seq.sv
// Sequencer for one shared complex MAC: gathers DECIMATION I/Q pairs, runs TAPS MAC
// cycles, then writes one result to the output FIFOs, stalling while they are full.
module fir_cmplx_seq
    import fir_cmplx_seq_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int DECIMATION = DEF_DECIMATION,
    parameter int TAP_W      = $clog2(TAPS),
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    fir_cmplx_seq_if.master  dp,
    output logic             busy,
    output logic [CNT_W-1:0] out_count
);
    localparam int DEC_W = cnt_width(DECIMATION);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             rd, mac, wr;
    logic [DEC_W-1:0] dec_cnt;
    logic             dec_wrap;
    logic [TAP_W-1:0] tap_cnt;
    logic             tap_wrap;

    // A partial decimation group must survive idle periods, so this counter is never cleared.
    mod_counter #(.MOD(DECIMATION), .W(DEC_W)) u_dec_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (rd),
        .count (dec_cnt),
        .wrap  (dec_wrap)
    );

    mod_counter #(.MOD(TAPS), .W(TAP_W)) u_tap_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q != S_MAC),
        .inc   (mac),
        .count (tap_cnt),
        .wrap  (tap_wrap)
    );

    always_comb begin
        state_d     = state_q;
        out_count_d = out_count_q;
        rd          = 1'b0;
        mac         = 1'b0;
        wr          = 1'b0;
        case (state_q)
            S_FILL: begin
                rd = enable & ~dp.i_empty & ~dp.q_empty;
                if (dec_wrap) state_d = S_MAC;
            end
            S_MAC: begin
                mac = 1'b1;
                if (tap_wrap) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr = ~dp.y_full;
                if (wr) begin
                    out_count_d = out_count_q + 1'b1;
                    state_d     = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_count_q <= out_count_d;
        end
    end

    // Strobes are gated by reset so the combinational FIFO-flag paths cannot leak through.
    assign dp.in_rd_en = reset & rd;
    assign dp.shift_en = reset & rd;
    assign dp.mac_en   = reset & mac;
    assign dp.mac_clr  = reset & mac & (tap_cnt == '0);
    assign dp.mac_last = reset & tap_wrap;
    assign dp.y_wr_en  = reset & wr;
    assign dp.tap_idx  = tap_cnt;

    assign busy      = (state_q != S_FILL) || (dec_cnt != '0);
    assign out_count = out_count_q;
endmodule
